motoro3_step_sequencer: RTL



---
 rtl/motoro3_step_sequencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/motoro3_step_sequencer.sv
// motoro3_step_sequencer: open-loop six-step commutation with align, soft-start ramp and run.
module motoro3_step_sequencer #(
  parameter int CNT_W = 25,
  parameter logic [CNT_W-1:0] ALIGN_PERIOD = 25'd5_000_000,
  parameter logic [CNT_W-1:0] START_PERIOD = 25'd2_000_000,
  parameter logic [CNT_W-1:0] MIN_PERIOD = 25'd20_000,
  parameter logic [CNT_W-1:0] RAMP_STEP = 25'd10_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dir,
  input  logic [CNT_W-1:0] period_tgt,
  output logic             aE,
  output logic             bE,
  output logic             cE,
  output logic             aH,
  output logic             bH,
  output logic             cH,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntLast1,
  output logic [2:0]       step,
  output logic             state_run
);
  typedef enum logic [1:0] {IDLE, ALIGN, RAMP, RUN} state_t;
  localparam logic [5:0] EN_A = 6'b011011;
  localparam logic [5:0] EN_B = 6'b101101;
  localparam logic [5:0] EN_C = 6'b110110;
  localparam logic [5:0] HI_A = 6'b000011;
  localparam logic [5:0] HI_B = 6'b001100;
  localparam logic [5:0] HI_C = 6'b110000;
  state_t state_q, state_d;
  logic [2:0] step_q, step_d, step_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [CNT_W-1:0] tgt_eff, dec, ramp_p;
  logic [5:0] out_q, out_d;
  logic bnd;
  always_comb begin
    tgt_eff = (period_tgt < MIN_PERIOD) ? MIN_PERIOD : period_tgt;
    dec = (period_q > RAMP_STEP) ? period_q - RAMP_STEP : '0;
    ramp_p = (dec > tgt_eff) ? dec : tgt_eff;
    bnd = (cnt_q == '0);
    step_nx = dir ? ((step_q == 3'd5) ? 3'd0 : step_q + 3'd1)
                  : ((step_q == 3'd0) ? 3'd5 : step_q - 3'd1);
    state_d = state_q;
    step_d = step_q;
    cnt_d = cnt_q - 1'b1;
    period_d = period_q;
    if (!run) begin
      state_d = IDLE;
      step_d = '0;
      cnt_d = '0;
      period_d = START_PERIOD;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ALIGN;
          step_d = '0;
          cnt_d = ALIGN_PERIOD - 1'b1;
        end
        ALIGN: if (bnd) begin
          state_d = RAMP;
          period_d = START_PERIOD;
          cnt_d = START_PERIOD - 1'b1;
          step_d = step_nx;
        end
        RAMP: if (bnd) begin
          state_d = (ramp_p == tgt_eff) ? RUN : RAMP;
          period_d = ramp_p;
          cnt_d = ramp_p - 1'b1;
          step_d = step_nx;
        end
        RUN: if (bnd) begin
          // Speed-ups are ramped, slow-downs take effect at once.
          period_d = (tgt_eff < period_q) ? ramp_p : tgt_eff;
          cnt_d = period_d - 1'b1;
          step_d = step_nx;
        end
      endcase
    end
    out_d = (state_d == IDLE) ? 6'd0 : {EN_A[step_d], EN_B[step_d], EN_C[step_d],
                                        HI_A[step_d], HI_B[step_d], HI_C[step_d]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= '0;
      cnt_q <= '0;
      period_q <= START_PERIOD;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      out_q <= out_d;
    end
  end
  assign {aE, bE, cE, aH, bH, cH} = out_q;
  assign m3cnt = cnt_q;
  assign m3cntLast1 = (cnt_q == 1);
  assign step = step_q;
  assign state_run = (state_q == RUN);
endmodule
